// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: circular FIFO with a first-word-fall-through read port,
// registered occupancy/status flags and a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo #(
  parameter int unsigned DBITS    = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  wr_data,
  input  logic              wr_tick,
  input  logic              rd,
  output logic [DBITS-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthLvl = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0] AfLvl    = (ADDR_W + 1)'(AF_LEVEL);

  logic [DBITS-1:0]  mem_q [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;

  logic              wr_accept;
  logic              rd_accept;
  logic              wr_drop;

  // A write into a full buffer still lands when the head is popped in the same cycle.
  assign wr_accept = wr_tick & (~full_q | rd);
  assign rd_accept = rd & ~empty_q;
  assign wr_drop   = wr_tick & full_q & ~rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_accept, rd_accept})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == DepthLvl);
    af_d    = (level_d >= AfLvl);
    // Set has priority over clear.
    if (wr_drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data     = empty_q ? '0 : mem_q[rd_ptr_q];
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the buffer.
module tb_uart_rx_fifo;

  localparam int Depth = 16;
  localparam int AfLvl = 12;

  logic       clk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_tick;
  logic       rd;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
  logic       clr_ovf;

  int n_checks;
  int n_errors;

  logic [7:0] model_q[$];
  logic       model_ovf;

  uart_rx_fifo #(
    .DBITS   (8),
    .ADDR_W  (4),
    .AF_LEVEL(AfLvl)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_tick    (wr_tick),
    .rd         (rd),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic w, input logic [7:0] d, input logic p,
                            input logic c);
    int  sz;
    bit  was_full;
    bit  was_empty;
    if (r) begin
      model_q.delete();
      model_ovf = 1'b0;
      return;
    end
    sz        = model_q.size();
    was_full  = (sz == Depth);
    was_empty = (sz == 0);
    if (w && was_full && !p) begin
      model_ovf = 1'b1;
    end else if (c) begin
      model_ovf = 1'b0;
    end
    if (p && !was_empty) void'(model_q.pop_front());
    if (w && (!was_full || p)) model_q.push_back(d);
  endtask

  task automatic compare_all();
    int sz;
    sz = model_q.size();
    check("level", 32'(level), 32'(sz));
    check("empty", 32'(empty), 32'(sz == 0));
    check("full", 32'(full), 32'(sz == Depth));
    check("almost_full", 32'(almost_full), 32'(sz >= AfLvl));
    check("overflow", 32'(overflow), 32'(model_ovf));
    check("rd_data", 32'(rd_data), (sz == 0) ? 32'h0 : 32'(model_q[0]));
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic p,
                      input logic c);
    reset   = r;
    wr_tick = w;
    wr_data = d;
    rd      = p;
    clr_ovf = c;
    @(posedge clk);
    model_edge(r, w, d, p, c);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    model_ovf = 1'b0;
    reset     = 1'b1;
    wr_tick   = 1'b0;
    wr_data   = 8'h00;
    rd        = 1'b0;
    clr_ovf   = 1'b0;

    // Reset then idle.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
    idle();
    check("reset_rd_data", 32'(rd_data), 32'h0);

    // Single byte in, single byte out.
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    check("single_head", 32'(rd_data), 32'hA5);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("single_drained", 32'(empty), 32'h1);

    // Fill 0x00..0x0F, then a dropped 17th write.
    for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'h1);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    check("drop_ovf", 32'(overflow), 32'h1);
    check("drop_level", 32'(level), 32'd16);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous write and pop.
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    check("full_wr_rd_level", 32'(level), 32'd16);
    check("full_wr_rd_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < Depth; i++) begin
      if (i == Depth - 1) check("last_is_77", 32'(rd_data), 32'h77);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Empty with simultaneous write and pop, then underflow attempt.
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    check("empty_wr_rd", 32'(rd_data), 32'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("underflow_ovf", 32'(overflow), 32'h0);

    // Overflow set/clear priority.
    for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hEF, 1'b0, 1'b1);
    check("set_beats_clear", 32'(overflow), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clear_alone", 32'(overflow), 32'h0);

    // Reset mid-operation with level 5.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    check("pre_reset_level", 32'(level), 32'd5);
    step(1'b1, 1'b1, 8'hAB, 1'b1, 1'b0);
    check("post_reset_level", 32'(level), 32'd0);

    // Randomized traffic in phases biased toward filling, draining or balance.
    for (int ph = 0; ph < 12; ph++) begin
      int wp;
      int rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int n = 0; n < 200; n++) begin
        step(($urandom_range(0, 499) == 0),
             ($urandom_range(0, 99) < wp),
             8'($urandom),
             ($urandom_range(0, 99) < rp),
             ($urandom_range(0, 19) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
